// File: rtl/spi_slave_if_if.sv
// Pin and word-handshake bundle between an SPI master model/pins and the spi_slave_if responder.
interface spi_slave_if_if #(
    parameter int DATA_W = 16
) ();
    logic              sclk;
    logic              cs_n;
    logic              mosi;
    logic              miso;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              tx_underrun;
    logic              frame_err;
    logic              busy;

    modport slave (
        input  sclk, cs_n, mosi, tx_data, tx_valid,
        output miso, tx_ready, rx_data, rx_valid, tx_underrun, frame_err, busy
    );

    modport master (
        output sclk, cs_n, mosi, tx_data, tx_valid,
        input  miso, tx_ready, rx_data, rx_valid, tx_underrun, frame_err, busy
    );
endinterface

// File: rtl/spi_slave_if.sv
// Oversampled SPI mode-0 slave with a one-deep TX holding buffer.
// Build option SPI_SLV_LSB_FIRST_EN: shift LSB first (default MSB first).
module spi_slave_if #(
    parameter int                DATA_W     = 16,
    parameter logic [DATA_W-1:0] DEFAULT_TX = {DATA_W{1'b0}}
) (
    input  logic          clk,
    input  logic          rst,
    spi_slave_if_if.slave bus
);
    localparam int               IDX_W    = $clog2(DATA_W);
    localparam int               CNT_W    = IDX_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);
`ifdef SPI_SLV_LSB_FIRST_EN
    localparam int               FIRST_IDX = 0;
`else
    localparam int               FIRST_IDX = DATA_W - 1;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_r;
    logic [2:0]        sclk_sync_r;
    logic [2:0]        cs_sync_r;
    logic [1:0]        mosi_sync_r;
    logic              sclk_rise_r;
    logic              sclk_fall_r;
    logic              cs_rise_r;
    logic              cs_fall_r;
    logic [CNT_W-1:0]  bit_cnt_r;
    logic [DATA_W-1:0] tx_word_r;
    logic [DATA_W-1:0] rx_sh_r;
    logic [DATA_W-1:0] rx_data_r;
    logic [DATA_W-1:0] buf_data_r;
    logic              buf_full_r;
    logic              tx_ready_r;
    logic              miso_r;
    logic              rx_valid_r;
    logic              tx_underrun_r;
    logic              frame_err_r;
    logic              busy_r;

    logic              frame_start_s;
    logic              tx_hs_s;
    logic [DATA_W-1:0] tx_load_s;
    logic [IDX_W-1:0]  bit_idx_s;
    logic [DATA_W-1:0] rx_next_s;

    // Synchronizers plus registered edge flags; cs chain resets low so a frame
    // already running when reset releases is not mistaken for a new cs_n fall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync_r <= 3'b000;
            cs_sync_r   <= 3'b000;
            mosi_sync_r <= 2'b00;
            sclk_rise_r <= 1'b0;
            sclk_fall_r <= 1'b0;
            cs_rise_r   <= 1'b0;
            cs_fall_r   <= 1'b0;
        end else begin
            sclk_sync_r <= {sclk_sync_r[1:0], bus.sclk};
            cs_sync_r   <= {cs_sync_r[1:0], bus.cs_n};
            mosi_sync_r <= {mosi_sync_r[0], bus.mosi};
            sclk_rise_r <= sclk_sync_r[1] & ~sclk_sync_r[2];
            sclk_fall_r <= ~sclk_sync_r[1] & sclk_sync_r[2];
            cs_rise_r   <= cs_sync_r[1] & ~cs_sync_r[2];
            cs_fall_r   <= ~cs_sync_r[1] & cs_sync_r[2];
        end
    end

    // Frame-start/handshake decode and the bit position addressed by the counter.
    always_comb begin
        frame_start_s = (state_r == ST_IDLE) && cs_fall_r;
        tx_hs_s       = bus.tx_valid && tx_ready_r;
        if (buf_full_r) begin
            tx_load_s = buf_data_r;
        end else begin
            tx_load_s = DEFAULT_TX;
        end
`ifdef SPI_SLV_LSB_FIRST_EN
        bit_idx_s = bit_cnt_r[IDX_W-1:0];
`else
        bit_idx_s = IDX_W'(DATA_W - 1) - bit_cnt_r[IDX_W-1:0];
`endif
        rx_next_s            = rx_sh_r;
        rx_next_s[bit_idx_s] = mosi_sync_r[1];
    end

    // Holding buffer: a handshake on the frame-start cycle still lands and waits for the next frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_data_r <= {DATA_W{1'b0}};
            buf_full_r <= 1'b0;
            tx_ready_r <= 1'b1;
        end else if (tx_hs_s) begin
            buf_data_r <= bus.tx_data;
            buf_full_r <= 1'b1;
            tx_ready_r <= 1'b0;
        end else if (frame_start_s) begin
            buf_full_r <= 1'b0;
            tx_ready_r <= 1'b1;
        end else begin
            buf_full_r <= buf_full_r;
            tx_ready_r <= tx_ready_r;
        end
    end

    // Frame state machine with registered pin and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            bit_cnt_r     <= {CNT_W{1'b0}};
            tx_word_r     <= {DATA_W{1'b0}};
            rx_sh_r       <= {DATA_W{1'b0}};
            rx_data_r     <= {DATA_W{1'b0}};
            miso_r        <= 1'b0;
            rx_valid_r    <= 1'b0;
            tx_underrun_r <= 1'b0;
            frame_err_r   <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            rx_valid_r    <= 1'b0;
            tx_underrun_r <= 1'b0;
            frame_err_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cs_fall_r) begin
                        tx_word_r     <= tx_load_s;
                        miso_r        <= tx_load_s[FIRST_IDX];
                        rx_sh_r       <= {DATA_W{1'b0}};
                        bit_cnt_r     <= {CNT_W{1'b0}};
                        tx_underrun_r <= ~buf_full_r;
                        busy_r        <= 1'b1;
                        state_r       <= ST_SHIFT;
                    end else begin
                        miso_r <= 1'b0;
                        busy_r <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (cs_rise_r) begin
                        frame_err_r <= 1'b1;
                        busy_r      <= 1'b0;
                        miso_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else if (sclk_rise_r) begin
                        rx_sh_r   <= rx_next_s;
                        bit_cnt_r <= bit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        // Last bit: publish the word directly so rx_valid comes one cycle after detection.
                        if ((bit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1}) == LAST_CNT) begin
                            rx_data_r  <= rx_next_s;
                            rx_valid_r <= 1'b1;
                            busy_r     <= 1'b0;
                            miso_r     <= 1'b0;
                            state_r    <= ST_DONE;
                        end else begin
                            state_r <= ST_SHIFT;
                        end
                    end else if (sclk_fall_r) begin
                        miso_r <= tx_word_r[bit_idx_s];
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    miso_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    miso_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.miso        = miso_r;
    assign bus.tx_ready    = tx_ready_r;
    assign bus.rx_data     = rx_data_r;
    assign bus.rx_valid    = rx_valid_r;
    assign bus.tx_underrun = tx_underrun_r;
    assign bus.frame_err   = frame_err_r;
    assign bus.busy        = busy_r;
endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: directed frames plus randomized frames against a word-level model.
module tb_spi_slave_if;
    localparam logic [15:0] DEF_TX = 16'h0000;

    logic clk = 1'b0;
    logic rst = 1'b0;

    spi_slave_if_if #(.DATA_W(16)) bus ();

    spi_slave_if #(.DATA_W(16), .DEFAULT_TX(DEF_TX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          n_rxv = 0;
    int          n_und = 0;
    int          n_ferr = 0;
    logic [15:0] last_rx = 16'h0000;
    logic [15:0] exp_rx  = 16'h0000;
    logic [15:0] mq[$];

    // Pulse counters sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.rx_valid) begin
            n_rxv   <= n_rxv + 1;
            last_rx <= bus.rx_data;
        end
        if (bus.tx_underrun) n_und <= n_und + 1;
        if (bus.frame_err) n_ferr <= n_ferr + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int bit_pos(input int i);
`ifdef SPI_SLV_LSB_FIRST_EN
        return i;
`else
        return 15 - i;
`endif
    endfunction

    task automatic push_tx(input logic [15:0] w);
        int waited = 0;
        @(negedge clk);
        while (!bus.tx_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check_eq("push_ready_wait", 32'(waited < 200), 32'd1);
        if (bus.tx_ready) begin
            bus.tx_data  = w;
            bus.tx_valid = 1'b1;
            @(negedge clk);
            bus.tx_valid = 1'b0;
            mq.push_back(w);
        end
    endtask

    task automatic spi_frame(input logic [15:0] word, input int nbits, input bit push_start,
                             input logic [15:0] pw, input int rst_at, output logic [15:0] got);
        got = 16'h0000;
        @(negedge clk);
        bus.cs_n = 1'b0;
        bus.mosi = word[bit_pos(0)];
        if (push_start) begin
            repeat (3) @(negedge clk);
            bus.tx_data  = pw;
            bus.tx_valid = 1'b1;
            @(negedge clk);
            bus.tx_valid = 1'b0;
            repeat (4) @(negedge clk);
        end else begin
            repeat (8) @(negedge clk);
        end
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rst = 1'b0;
                #1;
                check_eq("rst_miso", 32'(bus.miso), 32'd0);
                check_eq("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
                check_eq("rst_rx_data", 32'(bus.rx_data), 32'd0);
                check_eq("rst_busy", 32'(bus.busy), 32'd0);
                check_eq("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
                mq.delete();
                exp_rx = 16'h0000;
                @(negedge clk);
                rst = 1'b1;
            end
            if (i == 1 && rst_at < 0) begin
                check_eq("busy_mid", 32'(bus.busy), 32'd1);
                check_eq("tx_ready_mid", 32'(bus.tx_ready), 32'(mq.size() == 0));
            end
            got[bit_pos(i)] = bus.miso;
            bus.sclk = 1'b1;
            repeat (5) @(negedge clk);
            bus.sclk = 1'b0;
            if (i + 1 < nbits) bus.mosi = word[bit_pos(i + 1)];
            repeat (5) @(negedge clk);
        end
        bus.cs_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic run_frame(input logic [15:0] word, input int nbits, input bit push_start,
                             input logic [15:0] pw, input int rst_at);
        logic [15:0] exp_tx;
        logic [15:0] got;
        bit          exp_und;
        int          b_rxv, b_und, b_ferr;
        exp_und = (mq.size() == 0);
        exp_tx  = exp_und ? DEF_TX : mq.pop_front();
        if (push_start) mq.push_back(pw);
        b_rxv  = n_rxv;
        b_und  = n_und;
        b_ferr = n_ferr;
        spi_frame(word, nbits, push_start, pw, rst_at, got);
        if (rst_at >= 0) begin
            check_eq("rst_frame_rxv", 32'(n_rxv - b_rxv), 32'd0);
            check_eq("rst_frame_ferr", 32'(n_ferr - b_ferr), 32'd0);
        end else if (nbits == 16) begin
            exp_rx = word;
            check_eq("miso_word", 32'(got), 32'(exp_tx));
            check_eq("rxv_count", 32'(n_rxv - b_rxv), 32'd1);
            check_eq("rxv_data", 32'(last_rx), 32'(word));
            check_eq("ferr_none", 32'(n_ferr - b_ferr), 32'd0);
            check_eq("und_count", 32'(n_und - b_und), 32'(exp_und));
        end else begin
            check_eq("abort_ferr", 32'(n_ferr - b_ferr), 32'd1);
            check_eq("abort_rxv", 32'(n_rxv - b_rxv), 32'd0);
            check_eq("abort_und", 32'(n_und - b_und), 32'(exp_und));
        end
        check_eq("rx_data_held", 32'(bus.rx_data), 32'(exp_rx));
        check_eq("busy_idle", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.sclk = 1'b0;
        bus.cs_n = 1'b1;
        bus.mosi = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data = 16'h0000;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("reset_miso", 32'(bus.miso), 32'd0);
        check_eq("reset_tx_ready", 32'(bus.tx_ready), 32'd1);
        check_eq("reset_rx_data", 32'(bus.rx_data), 32'd0);
        check_eq("reset_rx_valid", 32'(bus.rx_valid), 32'd0);
        check_eq("reset_underrun", 32'(bus.tx_underrun), 32'd0);
        check_eq("reset_frame_err", 32'(bus.frame_err), 32'd0);
        check_eq("reset_busy", 32'(bus.busy), 32'd0);

        // Basic, underrun, abort
        push_tx(16'h5A5A);
        check_eq("tx_ready_full", 32'(bus.tx_ready), 32'd0);
        run_frame(16'hA5A5, 16, 1'b0, 16'h0000, -1);
        run_frame(16'h1234, 16, 1'b0, 16'h0000, -1);
        run_frame(16'hFFFF, 7, 1'b0, 16'h0000, -1);

        // Back-to-back with refill during the first frame
        push_tx(16'hBEEF);
        fork
            run_frame(16'h1111, 16, 1'b0, 16'h0000, -1);
            begin
                repeat (40) @(negedge clk);
                push_tx(16'hCAFE);
            end
        join
        run_frame(16'h2222, 16, 1'b0, 16'h0000, -1);

        // Handshake on the frame-start cycle: underrun now, word used next frame
        run_frame(16'h3333, 16, 1'b1, 16'h7777, -1);
        run_frame(16'h4444, 16, 1'b0, 16'h0000, -1);

        // Reset mid-frame, then a clean frame
        run_frame(16'h9999, 16, 1'b0, 16'h0000, 9);
        run_frame(16'h0F0F, 16, 1'b0, 16'h0000, -1);
        run_frame(16'h0001, 16, 1'b0, 16'h0000, -1);

        for (int k = 0; k < 24; k++) begin
            logic [15:0] w;
            int          nb;
            if (mq.size() == 0 && $urandom_range(1, 0) == 1) push_tx(16'($urandom));
            w  = 16'($urandom);
            nb = ($urandom_range(4, 0) == 0) ? int'($urandom_range(15, 1)) : 16;
            run_frame(w, nb, 1'b0, 16'h0000, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
